// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each requester owns a one-entry response buffer. The buffer accepts a new
// operation while it is empty, or in the same cycle its current result drains.
// FIXED_PRIO=0 alternates between requesters on a tie; FIXED_PRIO=1 always
// picks requester 0.
//
// state | meaning
// EMPTY | response buffer holds no result, rspN_valid=0
// FULL  | response buffer holds a result, rspN_valid=1
module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [4:0]  req0_shamt,
    input  logic        req0_use_shamt,
    input  logic [2:0]  req0_funct3,
    input  logic [6:0]  req0_funct7,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [4:0]  req1_shamt,
    input  logic        req1_use_shamt,
    input  logic [2:0]  req1_funct3,
    input  logic [6:0]  req1_funct7,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,
    output logic [3:0]  rsp0_flags,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,
    output logic [3:0]  rsp1_flags,

    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_shamt,
    output logic        alu_use_shamt,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t state0, state0_nxt;
    buf_state_t state1, state1_nxt;

    // 1 = requester 1 was granted last, so requester 0 wins the next tie
    logic       last_grant;
    logic       elig0, elig1;
    logic       grant0, grant1;
    logic       acc0, acc1;
    logic [3:0] alu_flags;

    assign alu_flags = {alu_carry, alu_negative, alu_zero, alu_overflow};

    // A buffer can take a new result when empty or when its result drains now
    assign req0_ready = rst_n && ((state0 == EMPTY) || rsp0_ready);
    assign req1_ready = rst_n && ((state1 == EMPTY) || rsp1_ready);

    assign elig0 = req0_valid && req0_ready;
    assign elig1 = req1_valid && req1_ready;
    assign acc0  = grant0;
    assign acc1  = grant1;

    assign rsp0_valid = (state0 == FULL);
    assign rsp1_valid = (state1 == FULL);

    // Pick at most one winner among the eligible requesters
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (FIXED_PRIO || last_grant) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (elig0) begin
            grant0 = 1'b1;
        end else if (elig1) begin
            grant1 = 1'b1;
        end
    end

    // Steer the winner's payload to the ALU; requester 0 when nobody wins
    always_comb begin
        alu_in1       = req0_in1;
        alu_in2       = req0_in2;
        alu_shamt     = req0_shamt;
        alu_use_shamt = req0_use_shamt;
        alu_funct3    = req0_funct3;
        alu_funct7    = req0_funct7;
        if (grant1) begin
            alu_in1       = req1_in1;
            alu_in2       = req1_in2;
            alu_shamt     = req1_shamt;
            alu_use_shamt = req1_use_shamt;
            alu_funct3    = req1_funct3;
            alu_funct7    = req1_funct7;
        end
    end

    // Buffer state register for both requesters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state0 <= EMPTY;
            state1 <= EMPTY;
        end else begin
            state0 <= state0_nxt;
            state1 <= state1_nxt;
        end
    end

    // Buffer next state: fill on accept, empty on drain without refill
    always_comb begin
        state0_nxt = state0;
        state1_nxt = state1;
        case (state0)
            EMPTY:   if (acc0) state0_nxt = FULL;
            FULL:    if (!acc0 && rsp0_ready) state0_nxt = EMPTY;
            default: state0_nxt = EMPTY;
        endcase
        case (state1)
            EMPTY:   if (acc1) state1_nxt = FULL;
            FULL:    if (!acc1 && rsp1_ready) state1_nxt = EMPTY;
            default: state1_nxt = EMPTY;
        endcase
    end

    // Capture the ALU result into the accepted requester's buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_out   <= '0;
            rsp0_flags <= '0;
            rsp1_out   <= '0;
            rsp1_flags <= '0;
        end else begin
            if (acc0) begin
                rsp0_out   <= alu_out;
                rsp0_flags <= alu_flags;
            end
            if (acc1) begin
                rsp1_out   <= alu_out;
                rsp1_flags <= alu_flags;
            end
        end
    end

    // Round-robin pointer moves only when an operation is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (acc0) begin
            last_grant <= 1'b0;
        end else if (acc1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: one round-robin and one fixed-priority instance
// share the same request stimulus, each with its own ALU model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        req0_use_shamt, req1_use_shamt;
    logic [2:0]  req0_funct3, req1_funct3;
    logic [6:0]  req0_funct7, req1_funct7;

    // round-robin instance signals
    logic        r_req0_ready, r_req1_ready, r_rsp0_valid, r_rsp1_valid;
    logic [31:0] r_rsp0_out, r_rsp1_out;
    logic [3:0]  r_rsp0_flags, r_rsp1_flags;
    logic [31:0] r_alu_in1, r_alu_in2, r_alu_out;
    logic [4:0]  r_alu_shamt;
    logic        r_alu_use_shamt;
    logic [2:0]  r_alu_funct3;
    logic [6:0]  r_alu_funct7;
    logic        r_c, r_n, r_z, r_v;

    // fixed-priority instance signals
    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp0_out, f_rsp1_out;
    logic [3:0]  f_rsp0_flags, f_rsp1_flags;
    logic [31:0] f_alu_in1, f_alu_in2, f_alu_out;
    logic [4:0]  f_alu_shamt;
    logic        f_alu_use_shamt;
    logic [2:0]  f_alu_funct3;
    logic [6:0]  f_alu_funct7;
    logic        f_c, f_n, f_z, f_v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, negative, zero, overflow, result}
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic us,
                                          input logic [2:0] f3, input logic [6:0] f7);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (f3)
            3'b000: begin
                if (f7[5]) begin
                    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                    r = s[31:0];
                    v = (a[31] != b[31]) && (r[31] != a[31]);
                end else begin
                    s = {1'b0, a} + {1'b0, b};
                    r = s[31:0];
                    v = (a[31] == b[31]) && (r[31] != a[31]);
                end
                c = s[32];
            end
            3'b001:  r = a << (us ? sh : b[4:0]);
            3'b100:  r = a ^ b;
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = '0;
        endcase
        return {c, r[31], (r == 32'd0), v, r};
    endfunction

    always_comb {r_c, r_n, r_z, r_v, r_alu_out} =
        alu_f(r_alu_in1, r_alu_in2, r_alu_shamt, r_alu_use_shamt, r_alu_funct3, r_alu_funct7);
    always_comb {f_c, f_n, f_z, f_v, f_alu_out} =
        alu_f(f_alu_in1, f_alu_in2, f_alu_shamt, f_alu_use_shamt, f_alu_funct3, f_alu_funct7);

    alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(r_req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_shamt(req0_shamt),
        .req0_use_shamt(req0_use_shamt), .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
        .req1_valid(req1_valid), .req1_ready(r_req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_shamt(req1_shamt),
        .req1_use_shamt(req1_use_shamt), .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
        .rsp0_valid(r_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(r_rsp0_out), .rsp0_flags(r_rsp0_flags),
        .rsp1_valid(r_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(r_rsp1_out), .rsp1_flags(r_rsp1_flags),
        .alu_in1(r_alu_in1), .alu_in2(r_alu_in2), .alu_shamt(r_alu_shamt),
        .alu_use_shamt(r_alu_use_shamt), .alu_funct3(r_alu_funct3), .alu_funct7(r_alu_funct7),
        .alu_out(r_alu_out), .alu_carry(r_c), .alu_negative(r_n), .alu_zero(r_z), .alu_overflow(r_v)
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_shamt(req0_shamt),
        .req0_use_shamt(req0_use_shamt), .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_shamt(req1_shamt),
        .req1_use_shamt(req1_use_shamt), .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(f_rsp0_out), .rsp0_flags(f_rsp0_flags),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(f_rsp1_out), .rsp1_flags(f_rsp1_flags),
        .alu_in1(f_alu_in1), .alu_in2(f_alu_in2), .alu_shamt(f_alu_shamt),
        .alu_use_shamt(f_alu_use_shamt), .alu_funct3(f_alu_funct3), .alu_funct7(f_alu_funct7),
        .alu_out(f_alu_out), .alu_carry(f_c), .alu_negative(f_n), .alu_zero(f_z), .alu_overflow(f_v)
    );

    typedef struct {
        bit          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        us;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] exp_out;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic us, input logic [2:0] f3, input logic [6:0] f7);
        if (n == 0) begin
            req0_valid = v; req0_in1 = a; req0_in2 = b; req0_shamt = sh;
            req0_use_shamt = us; req0_funct3 = f3; req0_funct7 = f7;
        end else begin
            req1_valid = v; req1_in1 = a; req1_in2 = b; req1_shamt = sh;
            req1_use_shamt = us; req1_funct3 = f3; req1_funct7 = f7;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd5,        32'd3,  5'd0, 1'b0, 3'b000, 7'h00, 32'd8,        4'b0000};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'd1,  5'd0, 1'b0, 3'b000, 7'h00, 32'd0,        4'b1010};
        vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'd1,  5'd0, 1'b0, 3'b000, 7'h00, 32'h80000000, 4'b0101};
        vecs[3] = '{1'b0, 32'd5,        32'd5,  5'd0, 1'b0, 3'b000, 7'h20, 32'd0,        4'b1010};
        vecs[4] = '{1'b1, 32'hF0,       32'h0F, 5'd0, 1'b0, 3'b100, 7'h00, 32'hFF,       4'b0000};
        vecs[5] = '{1'b1, 32'd1,        32'd0,  5'd4, 1'b1, 3'b001, 7'h00, 32'd16,       4'b0000};
        vecs[6] = '{1'b1, 32'hF0F0,     32'hFF00, 5'd0, 1'b0, 3'b111, 7'h00, 32'hF000,   4'b0000};
        vecs[7] = '{1'b1, 32'd3,        32'd5,  5'd0, 1'b0, 3'b000, 7'h20, 32'hFFFFFFFE, 4'b0100};

        rst_n = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 32'd5, 32'd3, 5'd0, 1'b0, 3'b000, 7'h00);
        set_req(1, 1'b1, 32'd3, 32'd5, 5'd0, 1'b0, 3'b000, 7'h20);
        tick();
        tick();
        // reset state, valid requests present but not accepted
        chk("reset_rsp0_valid", r_rsp0_valid, 0);
        chk("reset_rsp1_valid", r_rsp1_valid, 0);
        chk("reset_rsp0_out", r_rsp0_out, 0);
        chk("reset_rsp1_flags", r_rsp1_flags, 0);
        chk("reset_req0_ready", r_req0_ready, 0);
        chk("reset_req1_ready", r_req1_ready, 0);
        set_req(0, 1'b0, 0, 0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // single operations through each requester
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].who ? 1 : 0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sh,
                    vecs[i].us, vecs[i].f3, vecs[i].f7);
            tick();
            set_req(vecs[i].who ? 1 : 0, 1'b0, 32'hDEAD, 32'hBEEF, 5'd0, 1'b0, 3'b000, 7'h00);
            if (vecs[i].who) begin
                chk($sformatf("vec%0d_valid", i), r_rsp1_valid, 1);
                chk($sformatf("vec%0d_out", i), r_rsp1_out, vecs[i].exp_out);
                chk($sformatf("vec%0d_flags", i), r_rsp1_flags, vecs[i].exp_flags);
                chk($sformatf("vec%0d_fp_out", i), f_rsp1_out, vecs[i].exp_out);
            end else begin
                chk($sformatf("vec%0d_valid", i), r_rsp0_valid, 1);
                chk($sformatf("vec%0d_out", i), r_rsp0_out, vecs[i].exp_out);
                chk($sformatf("vec%0d_flags", i), r_rsp0_flags, vecs[i].exp_flags);
                chk($sformatf("vec%0d_fp_out", i), f_rsp0_out, vecs[i].exp_out);
            end
            tick();
            chk($sformatf("vec%0d_drained", i), {r_rsp0_valid, r_rsp1_valid}, 2'b00);
        end

        // tie under continuous dual demand
        do_reset();
        set_req(0, 1'b1, 32'd5, 32'd3, 5'd0, 1'b0, 3'b000, 7'h00);
        set_req(1, 1'b1, 32'd3, 32'd5, 5'd0, 1'b0, 3'b000, 7'h20);
        #1;
        chk("tie_alu_in1_first", r_alu_in1, 32'd5);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("tie%0d_rsp", k), {r_rsp0_valid, r_rsp1_valid}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 1) begin
                chk($sformatf("tie%0d_out1", k), r_rsp1_out, 32'hFFFFFFFE);
                chk($sformatf("tie%0d_flags1", k), r_rsp1_flags, 4'b0100);
            end else begin
                chk($sformatf("tie%0d_alu_f7", k), r_alu_funct7, 7'h20);
            end
            chk($sformatf("fp%0d_rsp", k), {f_rsp0_valid, f_rsp1_valid}, 2'b10);
        end
        set_req(0, 1'b0, 32'd5, 32'd3, 5'd0, 1'b0, 3'b000, 7'h00);
        tick();
        chk("fp_req1_after_drop_valid", f_rsp1_valid, 1);
        chk("fp_req1_after_drop_out", f_rsp1_out, 32'hFFFFFFFE);
        set_req(1, 1'b0, 0, 0, 0, 0, 0, 0);

        // backpressure on rsp0 while requester 1 keeps flowing
        do_reset();
        set_req(0, 1'b1, 32'd5, 32'd3, 5'd0, 1'b0, 3'b000, 7'h00);
        tick();
        chk("bp_first_out", r_rsp0_out, 32'd8);
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 32'hF0, 32'h0F, 5'd0, 1'b0, 3'b100, 7'h00);
        set_req(1, 1'b1, 32'd3, 32'd5, 5'd0, 1'b0, 3'b000, 7'h20);
        #1;
        chk("bp_req0_ready", r_req0_ready, 0);
        chk("bp_req1_ready", r_req1_ready, 1);
        tick();
        chk("bp_rsp1_out_a", r_rsp1_out, 32'hFFFFFFFE);
        chk("bp_rsp0_hold_a", {r_rsp0_valid, r_rsp0_out}, {1'b1, 32'd8});
        set_req(1, 1'b1, 32'd1, 32'd1, 5'd0, 1'b0, 3'b000, 7'h00);
        tick();
        chk("bp_rsp1_out_b", {r_rsp1_valid, r_rsp1_out}, {1'b1, 32'd2});
        chk("bp_rsp0_hold_b", {r_rsp0_valid, r_rsp0_out}, {1'b1, 32'd8});

        // drain-and-refill of rsp0
        set_req(1, 1'b0, 0, 0, 0, 0, 0, 0);
        rsp0_ready = 1'b1;
        #1;
        chk("refill_req0_ready", r_req0_ready, 1);
        tick();
        chk("refill_rsp0", {r_rsp0_valid, r_rsp0_out}, {1'b1, 32'hFF});
        // payload changes after accept must not reach the buffer
        rsp0_ready = 1'b0;
        set_req(0, 1'b0, 32'h1234, 32'h1, 5'd0, 1'b0, 3'b000, 7'h00);
        tick();
        chk("payload_sampled_once", {r_rsp0_valid, r_rsp0_out}, {1'b1, 32'hFF});

        // reset while rsp1 holds a stalled result
        rsp1_ready = 1'b0;
        set_req(1, 1'b1, 32'd5, 32'd3, 5'd0, 1'b0, 3'b000, 7'h00);
        tick();
        chk("mid_rsp1_full", {r_rsp1_valid, r_rsp1_out}, {1'b1, 32'd8});
        rst_n = 1'b0;
        #1;
        chk("mid_req1_ready_in_reset", r_req1_ready, 0);
        tick();
        chk("mid_rsp1_cleared", {r_rsp1_valid, r_rsp1_out, r_rsp1_flags}, 37'd0);
        chk("mid_rsp0_cleared", {r_rsp0_valid, r_rsp0_out}, 33'd0);
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 32'd5, 32'd3, 5'd0, 1'b0, 3'b000, 7'h00);
        set_req(1, 1'b1, 32'd3, 32'd5, 5'd0, 1'b0, 3'b000, 7'h20);
        tick();
        chk("post_reset_tie", {r_rsp0_valid, r_rsp1_valid}, 2'b10);
        chk("post_reset_out", r_rsp0_out, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
